// File: rtl/pc_call_stack.sv
// pc_call_stack
// Program counter for the timer sequencer with a hardware call/return stack.
// The mode controller drives load/call/ret/inc strobes; pc_out addresses the
// sequence ROM. Strobes are prioritised load > call > ret > inc and only the
// winning operation executes on a given rising edge. Stack misuse (call while
// full, ret while empty) is reported through sticky flags cleared by clr_err.

module pc_call_stack #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] MAX_ADDR  = {WIDTH{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       inc,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           load_val,
  output logic [WIDTH-1:0]           pc_out,
  output logic [$clog2(DEPTH+1)-1:0] sp_out,
  output logic                       empty,
  output logic                       full,
  output logic                       wrapped,
  output logic                       overflow,
  output logic                       underflow
);

  // Stack pointer counts occupancy 0..DEPTH; the memory index only needs
  // enough bits to address DEPTH entries.
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  // Decoded operation after priority resolution. The "blocked" variants are
  // calls/rets that hit a full/empty stack and only raise an error flag.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_CALL,
    OP_CALL_BLOCKED,
    OP_RET,
    OP_RET_BLOCKED,
    OP_INC
  } op_e;

  op_e               op;

  logic [WIDTH-1:0]  pc_q;
  logic [WIDTH-1:0]  pc_d;
  logic [SPW-1:0]    sp_q;
  logic [SPW-1:0]    sp_d;
  logic              wrapped_q;
  logic              wrapped_d;
  logic              overflow_q;
  logic              overflow_d;
  logic              underflow_q;
  logic              underflow_d;

  logic [WIDTH-1:0]  stack_mem [DEPTH];
  logic              push_en;
  logic [AW-1:0]     push_idx;
  logic [AW-1:0]     top_idx;
  logic [SPW-1:0]    sp_dec;

  logic              stack_empty;
  logic              stack_full;
  logic              at_max;
  logic [WIDTH-1:0]  pc_plus;

  // Occupancy status is purely a function of the stack pointer.
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_FULL);

  // Sequential successor of the PC. A PC above MAX_ADDR (reachable only via
  // load/call with an out-of-range target) also folds back to zero, so the
  // sequencer never runs off into unmapped ROM. The wrap pulse is reserved
  // for the genuine MAX_ADDR -> 0 transition.
  assign at_max  = (pc_q == MAX_ADDR);
  assign pc_plus = (pc_q >= MAX_ADDR) ? '0 : pc_q + WIDTH'(1);

  // Push writes the slot just above the current top; pop reads the top.
  assign sp_dec   = sp_q - SP_ONE;
  assign push_idx = sp_q[AW-1:0];
  assign top_idx  = sp_dec[AW-1:0];

  // Resolve simultaneous strobes into the single operation that executes.
  always_comb begin
    op = OP_NONE;
    if (load) begin
      op = OP_LOAD;
    end else if (call) begin
      op = stack_full ? OP_CALL_BLOCKED : OP_CALL;
    end else if (ret) begin
      op = stack_empty ? OP_RET_BLOCKED : OP_RET;
    end else if (inc) begin
      op = OP_INC;
    end
  end

  // Next-state computation for PC, stack pointer and flags.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    pc_d        = pc_q;
    sp_d        = sp_q;
    wrapped_d   = 1'b0;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    push_en     = 1'b0;

    case (op)
      OP_LOAD: begin
        pc_d = load_val;
      end
      OP_CALL: begin
        push_en = 1'b1;
        sp_d    = sp_q + SP_ONE;
        pc_d    = load_val;
      end
      OP_CALL_BLOCKED: begin
        // Error event wins over a same-cycle clr_err.
        overflow_d = 1'b1;
      end
      OP_RET: begin
        pc_d = stack_mem[top_idx];
        sp_d = sp_dec;
      end
      OP_RET_BLOCKED: begin
        underflow_d = 1'b1;
      end
      OP_INC: begin
        pc_d      = pc_plus;
        wrapped_d = at_max;
      end
      default: begin
      end
    endcase
  end

  // Architectural state: PC, stack pointer and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of ordering.
    if (!reset_n) begin
      pc_q        <= RESET_VAL;
      sp_q        <= '0;
      wrapped_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      wrapped_q   <= wrapped_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Return-address storage written on a successful call.
  // NOTE: the stack memory has no reset; entries above sp are never read, so
  // clearing them would only cost reset fan-out with no functional effect.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[push_idx] <= pc_plus;
    end
  end

  assign pc_out    = pc_q;
  assign sp_out    = sp_q;
  assign empty     = stack_empty;
  assign full      = stack_full;
  assign wrapped   = wrapped_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
